// File: rtl/store_pkg.sv
// Shared types and helpers for the store path: request encodings, buffer entry
// layout and bus-word address masking.
package store_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } st_size_e;

  typedef enum logic [1:0] {
    SW_NORM = 2'b00,
    SW_L    = 2'b01,
    SW_R    = 2'b10,
    SW_RSV  = 2'b11
  } st_swlr_e;

  // Sized for the widest bus; narrower instances leave the upper bits zero.
  typedef struct packed {
    logic [31:0]             addr;
    logic [MAX_DATA_W-1:0]   data;
    logic [MAX_STRB_W-1:0]   strb;
  } sb_entry_t;

  function automatic logic [31:0] word_addr(input logic [31:0] addr, input int data_w);
    logic [31:0] mask;
    mask = (data_w == 64) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
    return addr & mask;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store alignment: places the register value into its byte lanes
// and produces the matching strobe plus a misalignment/reserved-encoding flag.
module store_lane_align
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          addr_lo,
  input  st_size_e            size,
  input  st_swlr_e            swlr,
  input  logic [31:0]         wdata,
  output logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] strb,
  output logic                misalign
);

  logic [1:0]  o;
  logic [4:0]  sh_up;
  logic [4:0]  sh_dn;
  logic [31:0] d32;
  logic [3:0]  s4;

  assign o     = addr_lo[1:0];
  assign sh_up = {o, 3'b000};
  // SWL shifts right by 8*(3-o); for a 2-bit o, 3-o is simply ~o.
  assign sh_dn = {~o, 3'b000};

  always_comb begin
    d32      = wdata;
    s4       = 4'b1111;
    misalign = 1'b0;
    unique case (swlr)
      SW_L: begin
        d32 = wdata >> sh_dn;
        s4  = 4'b1111 >> ~o;
      end
      SW_R: begin
        d32 = wdata << sh_up;
        s4  = 4'b1111 << o;
      end
      SW_RSV: begin
        misalign = 1'b1;
      end
      SW_NORM: begin
        unique case (size)
          SZ_B: begin
            d32 = {24'h0, wdata[7:0]} << sh_up;
            s4  = 4'b0001 << o;
          end
          SZ_H: begin
            d32      = {16'h0, wdata[15:0]} << sh_up;
            s4       = 4'b0011 << o;
            misalign = o[0];
          end
          SZ_W: begin
            misalign = (o != 2'b00);
          end
          SZ_RSV: begin
            misalign = 1'b1;
          end
        endcase
      end
    endcase
  end

  generate
    if (DATA_W == 64) begin : g_lane64
      assign data = addr_lo[2] ? {d32, 32'h0} : {32'h0, d32};
      assign strb = addr_lo[2] ? {s4, 4'h0} : {4'h0, s4};
    end else begin : g_lane32
      logic unused_lane_sel;
      assign unused_lane_sel = addr_lo[2];
      assign data = d32;
      assign strb = s4;
    end
  endgenerate

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer: aligns incoming stores, queues them with optional tail merging,
// drains over a valid/ready bus and flags loads that hit a pending store.
module store_align_buffer
  import store_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter bit MERGE_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  input  logic [1:0]                 req_size,
  input  logic [1:0]                 req_swlr,
  output logic                       req_misalign,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic [31:0]                bus_addr,
  output logic [DATA_W-1:0]          bus_wdata,
  output logic [DATA_W/8-1:0]        bus_wstrb,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hit,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] al_data;
  logic [STRB_W-1:0] al_strb;

  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo  (req_addr[2:0]),
    .size     (st_size_e'(req_size)),
    .swlr     (st_swlr_e'(req_swlr)),
    .wdata    (req_wdata),
    .data     (al_data),
    .strb     (al_strb),
    .misalign (req_misalign)
  );

  sb_entry_t              mem [DEPTH];
  logic [DEPTH-1:0]       valid_reg, valid_next;
  logic [PTR_W-1:0]       head_reg, tail_reg, last_ptr;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [31:0]            req_waddr, ld_waddr;
  logic                   fire, merge, push, pop;
  sb_entry_t              head_e, last_e, new_e, merged_e;
  logic [MAX_DATA_W-1:0]  merged_data;
  logic [DEPTH-1:0]       hit_vec;

  assign req_waddr = word_addr(req_addr, DATA_W);
  assign ld_waddr  = word_addr(ld_addr, DATA_W);
  assign last_ptr  = tail_reg - PTR_W'(1);
  assign head_e    = mem[head_reg];
  assign last_e    = mem[last_ptr];

  assign empty     = (count_reg == '0);
  assign req_ready = (count_reg < DEPTH_C);
  assign bus_valid = !empty;
  assign fire      = req_valid & req_ready & ~req_misalign;
  // The head may be mid-handshake, so merging only ever targets a non-head tail.
  assign merge     = MERGE_EN && fire && (count_reg >= CNT_W'(2)) && (last_e.addr == req_waddr);
  assign push      = fire & ~merge;
  assign pop       = bus_valid & bus_ready;

  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    valid_next = valid_reg;
    if (pop)  valid_next[head_reg] = 1'b0;
    if (push) valid_next[tail_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_next;
      valid_reg <= valid_next;
    end
  end

  assign new_e.addr = req_waddr;
  assign new_e.data = MAX_DATA_W'(al_data);
  assign new_e.strb = MAX_STRB_W'(al_strb);

  generate
    for (genvar gi = 0; gi < MAX_STRB_W; gi++) begin : g_merge
      assign merged_data[8*gi +: 8] = new_e.strb[gi] ? new_e.data[8*gi +: 8]
                                                     : last_e.data[8*gi +: 8];
    end
  endgenerate

  assign merged_e.addr = last_e.addr;
  assign merged_e.data = merged_data;
  assign merged_e.strb = last_e.strb | new_e.strb;

  // Entry payload carries no reset; validity is tracked by valid_reg/count_reg.
  always_ff @(posedge clk) begin
    if (push)       mem[tail_reg] <= new_e;
    else if (merge) mem[last_ptr] <= merged_e;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit_vec[gi] = valid_reg[gi] && (mem[gi].addr == ld_waddr) &&
                           (|mem[gi].strb[STRB_W-1:0]);
    end
  endgenerate

  assign ld_hit    = |hit_vec;
  assign bus_addr  = head_e.addr;
  assign bus_wdata = head_e.data[DATA_W-1:0];
  assign bus_wstrb = head_e.strb[STRB_W-1:0];
  assign count     = count_reg;

  generate
    if (DATA_W < MAX_DATA_W) begin : g_narrow
      logic unused_head_hi;
      assign unused_head_hi = ^{head_e.data[MAX_DATA_W-1:DATA_W], head_e.strb[MAX_STRB_W-1:STRB_W]};
    end
  endgenerate

endmodule
